mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction fetch requester (IF stage) and the data requester (MEM stage load/store).
- Arbitrates requests and sequences one outstanding memory transaction at a time through a request/grant/response handshake.
- Routes each response back to the requester that owns the transaction.
- Discards fetch responses squashed by a branch redirect or misprediction flush.

Parameters:
- DATA_WIDTH, 32, width of read/write data.
- ADDR_WIDTH, 32, width of byte address.
- MAX_DATA_STREAK, 4, max consecutive data grants while fetch waits (must be >= 1).

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_flush  in  1  squash in-flight and pending fetch
- if_gnt  out  1  fetch request accepted
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  DATA_WIDTH  fetched instruction
- dm_req  in  1  data request; held with the dm_* fields until dm_gnt
- dm_we  in  1  1 = store
- dm_be  in  DATA_WIDTH/8  byte enables
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_gnt  out  1  data request accepted
- dm_rvalid  out  1  load data or store ack, 1-cycle pulse
- dm_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory request
- mem_we, mem_be, mem_addr, mem_wdata  out  as dm_*  registered request fields
- mem_gnt  in  1  memory accepted mem_req
- mem_rvalid  in  1  memory response, one per granted request (reads and writes)
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (arst high, async): state IDLE; all outputs 0; streak counter 0; drop flag 0; owner 0. Reset mid-transaction abandons it silently; the memory is reset by the same arst.
- FSM states:
  - IDLE: arbitrate. The winner's gnt is asserted combinationally this cycle. Its fields are latched into mem_* and the owner is recorded; next state REQ. If there is no request, stay in IDLE.
  - REQ: mem_req = 1 and mem_* are held stable until mem_gnt. On mem_gnt go to RESP. mem_req is never withdrawn once raised. mem_rvalid in REQ is ignored.
  - RESP: wait for mem_rvalid, then go to IDLE. On the next cycle the owner's rvalid pulses for one cycle with rdata registered from mem_rdata. rvalid is suppressed if the owner is fetch and the drop flag is set.
- Arbitration in IDLE:
  - Effective fetch request = if_req & ~if_flush.
  - Data wins by default.
  - Fetch wins if data is not requesting, or if the streak counter == MAX_DATA_STREAK and fetch is requesting.
  - Only one gnt per cycle; gnts occur only in IDLE.
- Streak counter (width $clog2(MAX_DATA_STREAK+1)):
  - +1 on each data grant made while the effective fetch request is high, saturating at MAX_DATA_STREAK.
  - Cleared on a fetch grant, or in any IDLE cycle with the effective fetch request low.
- Flush:
  - if_flush while owner = fetch in REQ or RESP sets the drop flag. The transaction still completes on the memory side; if_rvalid is not asserted.
  - if_flush in the same cycle mem_rvalid arrives also drops.
  - The drop flag clears on entering IDLE.
  - if_flush while owner = data has no effect.
- Latency with a zero-wait memory (mem_gnt same cycle, mem_rvalid the cycle after gnt): accept at cycle N, rvalid at N+3, next accept possible at N+3. Throughput is one transaction per 3 cycles.
- rdata outputs hold their last value between pulses. dm_rdata after a store is don't-care.

Test Plan:
- Fetch only, zero-wait memory, if_req at cycle 0, addr 0x100, mem_rdata 0x00500093 -> if_gnt @0; mem_req @1 with mem_addr 0x100; if_rvalid @3 with if_rdata 0x00500093; busy 1 during cycles 1-2.
- if_req and dm_req both held continuously, MAX_DATA_STREAK = 4 -> grant order D,D,D,D,F,D,D,D,D,F; fetch never waits more than 4 data transactions.
- Store dm_we = 1, dm_be = 4'b0011, addr 0x2000, wdata 0xDEADBEEF, mem_gnt delayed 2 cycles -> mem_* stable for 3 REQ cycles; dm_rvalid exactly once, one cycle after mem_rvalid.
- Fetch granted, if_flush during RESP, mem_rvalid 2 cycles later -> if_rvalid never asserts; arbiter is back in IDLE and grants a pending dm_req on the next cycle.
- if_req with if_flush in the same IDLE cycle, no dm_req -> no if_gnt; FSM stays IDLE.
- arst pulsed during RESP -> all outputs 0 immediately; a subsequent if_req is granted the first cycle after arst deasserts; no stale rvalid appears.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// One transaction in flight at a time; responses are routed back to whichever side owns it.
module mem_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_flush,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    output logic                    dm_gnt,
    output logic                    dm_rvalid,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic [1:0]              o_dbg_state
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [SW-1:0]           r_streak;
    logic                    r_owner_if;
    logic                    r_drop;
    logic                    r_mem_we;
    logic [DATA_WIDTH/8-1:0] r_mem_be;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic                    r_if_rvalid;
    logic                    r_dm_rvalid;
    logic [DATA_WIDTH-1:0]   r_if_rdata;
    logic [DATA_WIDTH-1:0]   r_dm_rdata;

    logic w_if_eff;
    logic w_fetch_wins;
    logic w_gnt_if;
    logic w_gnt_dm;

    // Grants are combinational from IDLE; gating with arst keeps every output low while reset is held.
    always_comb begin
        w_if_eff     = if_req & ~if_flush;
        w_fetch_wins = w_if_eff & (~dm_req | (r_streak == STREAK_MAX));
        w_gnt_if     = (r_state == S_IDLE) & ~arst & w_fetch_wins;
        w_gnt_dm     = (r_state == S_IDLE) & ~arst & dm_req & ~w_fetch_wins;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_if | w_gnt_dm) w_next = S_REQ;
            S_REQ:   if (mem_gnt)             w_next = S_RESP;
            S_RESP:  if (mem_rvalid)          w_next = S_IDLE;
            default:                          w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_owner_if  <= 1'b0;
            r_drop      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_state     <= w_next;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_gnt_if) begin
                        r_owner_if  <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_streak    <= '0;
                    end else begin
                        if (w_gnt_dm) begin
                            r_owner_if  <= 1'b0;
                            r_mem_we    <= dm_we;
                            r_mem_be    <= dm_be;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                        end
                        // Streak only grows while fetch is actually being held off.
                        if (!w_if_eff)
                            r_streak <= '0;
                        else if (w_gnt_dm && (r_streak != STREAK_MAX))
                            r_streak <= r_streak + SW'(1);
                    end
                end
                S_REQ: begin
                    if (r_owner_if && if_flush) r_drop <= 1'b1;
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        r_drop <= 1'b0;
                        if (r_owner_if) begin
                            if (!(r_drop || if_flush)) begin
                                r_if_rvalid <= 1'b1;
                                r_if_rdata  <= mem_rdata;
                            end
                        end else begin
                            r_dm_rvalid <= 1'b1;
                            r_dm_rdata  <= mem_rdata;
                        end
                    end else if (r_owner_if && if_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_gnt      = w_gnt_if;
    assign dm_gnt      = w_gnt_dm;
    assign if_rvalid   = r_if_rvalid;
    assign if_rdata    = r_if_rdata;
    assign dm_rvalid   = r_dm_rvalid;
    assign dm_rdata    = r_dm_rdata;
    assign mem_req     = (r_state == S_REQ);
    assign mem_we      = r_mem_we;
    assign mem_be      = r_mem_be;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scripted scenarios against a behavioural memory with
// configurable grant/response delays; scoreboard queues hold expected grants and read data.
module tb_mem_port_arbiter;
    logic        clk;
    logic        arst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .arst(arst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          dm_pulses = 0;
    logic [0:0]  gnt_exp_q[$];   // 1 = fetch expected to win, 0 = data
    logic [31:0] if_exp_q[$];
    logic [32:0] dm_exp_q[$];    // bit 32 set = compare data, clear = store ack
    logic [31:0] mem_arr [logic [31:0]];
    int          gnt_delay = 0;
    int          rsp_delay = 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- memory model ----------------
    int          mm_gcnt;
    int          mm_rcnt;
    logic [31:0] mm_data;
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        mm_gcnt = 0; mm_rcnt = 0; mm_data = '0;
        forever begin
            @(negedge clk or posedge arst);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (arst) begin
                mm_gcnt = 0;
                mm_rcnt = 0;
            end else if (mm_rcnt > 0) begin
                mm_rcnt--;
                if (mm_rcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mm_data;
                end
            end else if (mem_req) begin
                if (mm_gcnt >= gnt_delay) begin
                    logic [31:0] cur;
                    mem_gnt = 1'b1;
                    mm_gcnt = 0;
                    mm_rcnt = rsp_delay;
                    if (mem_we) begin
                        cur = mem_rd(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_arr[mem_addr] = cur;
                        mm_data = 32'hFFFF_FFFF;
                    end else begin
                        mm_data = mem_rd(mem_addr);
                    end
                end else begin
                    mm_gcnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [0:0]  g;
        logic [31:0] e;
        logic [32:0] d;
        #2;
        if (!arst) begin
            if (if_gnt && dm_gnt) begin
                check_eq("dual_gnt", 1, 0);
            end else if (if_gnt || dm_gnt) begin
                if (gnt_exp_q.size() == 0) check_eq("gnt_unexpected", {63'd0, if_gnt}, 64'd2);
                else begin
                    g = gnt_exp_q.pop_front();
                    check_eq("gnt_owner", {63'd0, if_gnt}, {63'd0, g});
                end
            end
            if (if_rvalid) begin
                if (if_exp_q.size() == 0) check_eq("if_rvalid_unexpected", 1, 0);
                else begin
                    e = if_exp_q.pop_front();
                    check_eq("if_rdata", if_rdata, e);
                end
            end
            if (dm_rvalid) begin
                dm_pulses++;
                if (dm_exp_q.size() == 0) check_eq("dm_rvalid_unexpected", 1, 0);
                else begin
                    d = dm_exp_q.pop_front();
                    if (d[32]) check_eq("dm_rdata", dm_rdata, d[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fetch_req(input logic [31:0] a, input bit push, input logic [31:0] exp,
                             output int waited);
        if_req  = 1'b1;
        if_addr = a;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (if_gnt) begin
                if (push) if_exp_q.push_back(exp);
                waited = i;
                return;
            end
            @(negedge clk);
        end
        waited = 200;
        check_eq("if_gnt_timeout", 0, 1);
        if_req = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd, input logic [32:0] exp);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_be    = be;
        dm_addr  = a;
        dm_wdata = wd;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (dm_gnt) begin
                dm_exp_q.push_back(exp);
                return;
            end
            @(negedge clk);
        end
        check_eq("dm_gnt_timeout", 0, 1);
        dm_req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #3;
            if (!busy && if_exp_q.size() == 0 && dm_exp_q.size() == 0 && gnt_exp_q.size() == 0)
                return;
        end
        check_eq("drain_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_if_gnt"},    if_gnt, 0);
        check_eq({tag, "_if_rvalid"}, if_rvalid, 0);
        check_eq({tag, "_if_rdata"},  if_rdata, 0);
        check_eq({tag, "_dm_gnt"},    dm_gnt, 0);
        check_eq({tag, "_dm_rvalid"}, dm_rvalid, 0);
        check_eq({tag, "_dm_rdata"},  dm_rdata, 0);
        check_eq({tag, "_mem_req"},   mem_req, 0);
        check_eq({tag, "_mem_fields"}, {mem_we, mem_be, mem_addr}, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        check_eq({tag, "_busy"},      busy, 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int w;
        arst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
        mem_arr[32'h100] = 32'h0050_0093;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);

        // Fetch only, zero-wait memory
        gnt_delay = 0; rsp_delay = 1;
        gnt_exp_q.push_back(1'b1);
        fetch_req(32'h100, 1, 32'h0050_0093, w);
        check_eq("t1_gnt_cycle", w, 0);
        @(negedge clk); if_req = 1'b0;
        #2 check_eq("t1_c1_mem_req", mem_req, 1);
        check_eq("t1_c1_mem_addr", mem_addr, 32'h100);
        check_eq("t1_c1_busy", busy, 1);
        @(negedge clk); #2 check_eq("t1_c2_busy", busy, 1);
        @(negedge clk); #2 check_eq("t1_c3_if_rvalid", if_rvalid, 1);
        check_eq("t1_c3_if_rdata", if_rdata, 32'h0050_0093);
        check_eq("t1_c3_busy", busy, 0);
        @(negedge clk); #2 check_eq("t1_c4_if_rvalid", if_rvalid, 0);
        check_eq("t1_c4_rdata_hold", if_rdata, 32'h0050_0093);
        wait_drain();

        // Both requesters held continuously: fetch every fifth grant
        @(negedge clk);
        gnt_delay = $urandom_range(0, 2);
        rsp_delay = $urandom_range(1, 3);
        for (int i = 0; i < 10; i++) gnt_exp_q.push_back((i % 5) == 4);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] a;
                    a = 32'h3000 + 32'($urandom_range(0, 255)) * 4;
                    data_req(0, 4'hF, a, 32'h0, {1'b1, mem_rd(a)});
                    @(negedge clk);
                end
                dm_req = 1'b0;
            end
            begin
                int fw;
                for (int i = 0; i < 2; i++) begin
                    logic [31:0] a;
                    a = 32'h400 + 32'(i) * 4;
                    fetch_req(a, 1, mem_rd(a), fw);
                    @(negedge clk);
                end
                if_req = 1'b0;
            end
        join
        wait_drain();

        // Store with delayed memory grant
        @(negedge clk);
        gnt_delay = 2; rsp_delay = 1;
        w = dm_pulses;
        gnt_exp_q.push_back(1'b0);
        data_req(1, 4'b0011, 32'h2000, 32'hDEAD_BEEF, {1'b0, 32'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) dm_req = 1'b0;
            #2 check_eq("st_mem_req", mem_req, 1);
            check_eq("st_mem_ctl", {mem_we, mem_be}, {1'b1, 4'b0011});
            check_eq("st_mem_addr", mem_addr, 32'h2000);
            check_eq("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        for (int i = 0; i < 20 && !mem_rvalid; i++) begin @(negedge clk); #2; end
        check_eq("st_mem_rvalid_seen", mem_rvalid, 1);
        @(negedge clk); #2 check_eq("st_dm_rvalid", dm_rvalid, 1);
        @(negedge clk); #2 check_eq("st_dm_rvalid_once", dm_rvalid, 0);
        wait_drain();
        check_eq("st_pulse_count", dm_pulses - w, 1);
        gnt_delay = 0;
        gnt_exp_q.push_back(1'b0);
        @(negedge clk);
        data_req(0, 4'hF, 32'h2000, 32'h0, {1'b1, 32'h5A5A_BEEF});
        @(negedge clk); dm_req = 1'b0;
        wait_drain();

        // Flush during RESP, data pending behind it
        @(negedge clk);
        rsp_delay = 3;
        gnt_exp_q.push_back(1'b1);
        gnt_exp_q.push_back(1'b0);
        fetch_req(32'h500, 0, 32'h0, w);
        @(negedge clk);
        if_req = 1'b0;
        fork
            begin
                data_req(0, 4'hF, 32'h3100, 32'h0, {1'b1, mem_rd(32'h3100)});
                @(negedge clk); dm_req = 1'b0;
            end
            begin
                @(negedge clk); if_flush = 1'b1;
                @(negedge clk); if_flush = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk); #2;
                    if (!busy) break;
                end
                check_eq("fl_idle_busy", busy, 0);
                check_eq("fl_dm_gnt_first_idle", dm_gnt, 1);
                check_eq("fl_if_rvalid", if_rvalid, 0);
            end
        join
        wait_drain();

        // Flush in the same cycle as mem_rvalid
        @(negedge clk);
        rsp_delay = 1;
        gnt_exp_q.push_back(1'b1);
        fetch_req(32'h600, 0, 32'h0, w);
        @(negedge clk); if_req = 1'b0;
        @(negedge clk); if_flush = 1'b1;
        @(negedge clk); if_flush = 1'b0;
        #2 check_eq("flrv_if_rvalid", if_rvalid, 0);
        check_eq("flrv_idle", busy, 0);
        wait_drain();

        // Request and flush together in IDLE: nothing granted
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h640; if_flush = 1'b1;
        #1 check_eq("fi_if_gnt", if_gnt, 0);
        @(negedge clk); #2 check_eq("fi_busy", busy, 0);
        check_eq("fi_state", dbg_state, 2'd0);
        if_req = 1'b0; if_flush = 1'b0;

        // Reset in RESP, then a fresh fetch
        @(negedge clk);
        rsp_delay = 4;
        gnt_exp_q.push_back(1'b1);
        fetch_req(32'h700, 0, 32'h0, w);
        @(negedge clk); if_req = 1'b0;
        @(negedge clk);
        #1 check_eq("rs_in_resp", dbg_state, 2'd2);
        arst = 1'b1;
        #1 check_all_zero("rs_async");
        @(negedge clk);
        arst = 1'b0;
        rsp_delay = 1;
        gnt_exp_q.push_back(1'b1);
        fetch_req(32'h104, 1, mem_rd(32'h104), w);
        check_eq("rs_first_cycle_gnt", w, 0);
        @(negedge clk); if_req = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);

        check_eq("end_if_q_empty", if_exp_q.size(), 0);
        check_eq("end_dm_q_empty", dm_exp_q.size(), 0);
        check_eq("end_gnt_q_empty", gnt_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
